// File: rtl/hearing_aid_pkg.sv
// Shared audio-path constants and the serializer state type.
package hearing_aid_pkg;

    localparam int DATA_W = 24;
    localparam int SLOT_W = 32;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } tx_state_t;

endpackage

// File: rtl/audio_sample_fifo.sv
// Small synchronous sample buffer; read data is presented from the head entry.
module audio_sample_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full,
    output logic [LW-1:0]    level
);

    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Gate requests by occupancy so an empty pop never sees a same-cycle push.
    always_comb begin
        do_push = push && !full;
        do_pop  = pop && !empty;
    end

    assign empty   = (level == LW'(0));
    assign full    = (level == FULL_LVL);
    assign rd_data = mem[rd_ptr];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= AW'(0);
            rd_ptr <= AW'(0);
            level  <= LW'(0);
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // Sample storage.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: rtl/output_i2s_tx.sv
// Mono I2S transmitter: buffers samples and serializes each one into both slots.
module output_i2s_tx #(
    parameter int DATA_W     = hearing_aid_pkg::DATA_W,
    parameter int SLOT_W     = hearing_aid_pkg::SLOT_W,
    parameter int BCLK_DIV   = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             enable,
    input  logic                             mute,
    input  logic                             in_valid,
    input  logic [DATA_W-1:0]                in_data,
    output logic                             in_ready,
    input  logic                             clear_underflow,
    output logic                             i2s_bclk,
    output logic                             i2s_lrclk,
    output logic                             i2s_sdata,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level,
    output logic                             underflow_sticky
);

    import hearing_aid_pkg::*;

    localparam int DIV_W = $clog2(BCLK_DIV);
    localparam int BIT_W = $clog2(2 * SLOT_W);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * SLOT_W - 1);
    localparam logic [BIT_W-1:0] SLOT_LEN = BIT_W'(SLOT_W);
    localparam logic [BIT_W-1:0] DATA_LEN = BIT_W'(DATA_W);

    tx_state_t         state;
    logic [DIV_W-1:0]  div_cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] frame_sample;

    logic              fifo_empty;
    logic              fifo_full;
    logic [DATA_W-1:0] fifo_data;
    logic              push;
    logic              pop;
    logic              load;
    logic              bclk_fall;
    logic [DATA_W-1:0] load_sample;
    logic [BIT_W-1:0]  next_bit;
    logic [BIT_W-1:0]  slot_bit;
    logic [DATA_W-1:0] shifted;
    logic              next_lrclk;
    logic              next_sdata;

    assign in_ready = !fifo_full;

    audio_sample_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .wr_data (in_data),
        .pop     (pop),
        .rd_data (fifo_data),
        .empty   (fifo_empty),
        .full    (fifo_full),
        .level   (fifo_level)
    );

    // Load decisions: entry into RUN and every frame wrap fetch a new sample.
    always_comb begin
        push      = in_valid && in_ready;
        bclk_fall = (state == RUN) && (div_cnt == DIV_LAST) && i2s_bclk;
        if (state == IDLE) begin
            load = enable;
        end else begin
            load = enable && bclk_fall && (bit_cnt == BIT_LAST);
        end
        pop = load && !fifo_empty;
        if (fifo_empty || mute) begin
            load_sample = '0;
        end else begin
            load_sample = fifo_data;
        end
    end

    // Next serial bit: slot bit 0 is the I2S one-bit delay, then MSB-first data, then padding.
    always_comb begin
        if (bit_cnt == BIT_LAST) begin
            next_bit = BIT_W'(0);
        end else begin
            next_bit = bit_cnt + BIT_W'(1);
        end
        next_lrclk = (next_bit >= SLOT_LEN);
        if (next_lrclk) begin
            slot_bit = next_bit - SLOT_LEN;
        end else begin
            slot_bit = next_bit;
        end
        shifted = frame_sample << (slot_bit - BIT_W'(1));
        if ((slot_bit != BIT_W'(0)) && (slot_bit <= DATA_LEN)) begin
            next_sdata = shifted[DATA_W-1];
        end else begin
            next_sdata = 1'b0;
        end
    end

    // Serializer state machine with bit-clock divider and frame counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            div_cnt   <= DIV_W'(0);
            bit_cnt   <= BIT_W'(0);
            i2s_bclk  <= 1'b0;
            i2s_lrclk <= 1'b0;
            i2s_sdata <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    div_cnt   <= DIV_W'(0);
                    bit_cnt   <= BIT_W'(0);
                    i2s_bclk  <= 1'b0;
                    i2s_lrclk <= 1'b0;
                    i2s_sdata <= 1'b0;
                    state     <= enable ? RUN : IDLE;
                end
                RUN: begin
                    if (!enable) begin
                        state     <= IDLE;
                        div_cnt   <= DIV_W'(0);
                        bit_cnt   <= BIT_W'(0);
                        i2s_bclk  <= 1'b0;
                        i2s_lrclk <= 1'b0;
                        i2s_sdata <= 1'b0;
                    end else if (div_cnt == DIV_LAST) begin
                        div_cnt  <= DIV_W'(0);
                        i2s_bclk <= ~i2s_bclk;
                        // Data and word select change on the falling edge only.
                        if (i2s_bclk) begin
                            bit_cnt   <= next_bit;
                            i2s_lrclk <= next_lrclk;
                            i2s_sdata <= next_sdata;
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                default: begin
                    state     <= IDLE;
                    div_cnt   <= DIV_W'(0);
                    bit_cnt   <= BIT_W'(0);
                    i2s_bclk  <= 1'b0;
                    i2s_lrclk <= 1'b0;
                    i2s_sdata <= 1'b0;
                end
            endcase
        end
    end

    // Frame sample register, held constant between loads.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_sample <= '0;
        end else if (load) begin
            frame_sample <= load_sample;
        end else begin
            frame_sample <= frame_sample;
        end
    end

    // Underflow flag: a load from an empty buffer wins over a same-cycle clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            underflow_sticky <= 1'b0;
        end else if (load && fifo_empty) begin
            underflow_sticky <= 1'b1;
        end else if (clear_underflow) begin
            underflow_sticky <= 1'b0;
        end else begin
            underflow_sticky <= underflow_sticky;
        end
    end

endmodule

// File: tb/tb_output_i2s_tx.sv
// Scoreboard bench: stimulus queues expected frame samples, a monitor deserializes and checks frames.
module tb_output_i2s_tx;

    localparam int DATA_W     = 24;
    localparam int SLOT_W     = 32;
    localparam int BCLK_DIV   = 2;
    localparam int FIFO_DEPTH = 4;
    localparam int FRAME_CYC  = 2 * SLOT_W * 2 * BCLK_DIV;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              enable = 1'b0;
    logic              mute = 1'b0;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_ready;
    logic              clear_underflow = 1'b0;
    logic              i2s_bclk;
    logic              i2s_lrclk;
    logic              i2s_sdata;
    logic [2:0]        fifo_level;
    logic              underflow_sticky;

    always #5 clk = ~clk;

    output_i2s_tx #(
        .DATA_W     (DATA_W),
        .SLOT_W     (SLOT_W),
        .BCLK_DIV   (BCLK_DIV),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .enable           (enable),
        .mute             (mute),
        .in_valid         (in_valid),
        .in_data          (in_data),
        .in_ready         (in_ready),
        .clear_underflow  (clear_underflow),
        .i2s_bclk         (i2s_bclk),
        .i2s_lrclk        (i2s_lrclk),
        .i2s_sdata        (i2s_sdata),
        .fifo_level       (fifo_level),
        .underflow_sticky (underflow_sticky)
    );

    int                n_tests = 0;
    int                n_fail = 0;
    logic [DATA_W-1:0] exp_q[$];
    int                frames_done = 0;
    int                bitpos = 0;
    int                cyc = 0;
    int                start_cyc = 0;
    logic              prev_bclk = 1'b0;
    logic [63:0]       sd;
    logic [63:0]       lr;
    logic [23:0]       left_w;
    logic [23:0]       right_w;
    logic [23:0]       exp_w;
    int                pad_ones;
    int                base;
    logic [23:0]       vals [5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    // Monitor: samples serial data on each BCLK rising edge and checks whole frames.
    always @(negedge clk) begin
        cyc++;
        if (rst || !enable) begin
            bitpos = 0;
        end else if (i2s_bclk === 1'b1 && prev_bclk === 1'b0) begin
            if (bitpos == 0) start_cyc = cyc;
            sd[bitpos] = i2s_sdata;
            lr[bitpos] = i2s_lrclk;
            bitpos++;
            if (bitpos == 64) begin
                for (int k = 0; k < 24; k++) begin
                    left_w[23-k]  = sd[1+k];
                    right_w[23-k] = sd[33+k];
                end
                pad_ones = 0;
                for (int k = 0; k < 64; k++) begin
                    if ((k % 32) == 0 || (k % 32) > 24) pad_ones += int'(sd[k]);
                end
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_frame: actual left %0h required no frame", left_w);
                end else begin
                    exp_w = exp_q.pop_front();
                    check("left_slot", 64'(left_w), 64'(exp_w));
                    check("right_slot", 64'(right_w), 64'(exp_w));
                end
                check("pad_bits", 64'(pad_ones), 64'd0);
                check("lrclk_pattern", lr, 64'hFFFF_FFFF_0000_0000);
                check("bclk_period", 64'(cyc - start_cyc), 64'(FRAME_CYC - 2 * BCLK_DIV));
                bitpos = 0;
                frames_done++;
            end
        end
        prev_bclk = i2s_bclk;
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; enable = 1'b0; mute = 1'b0; in_valid = 1'b0; clear_underflow = 1'b0;
        @(negedge clk);
        check("rst_bclk", 64'(i2s_bclk), 64'd0);
        check("rst_lrclk", 64'(i2s_lrclk), 64'd0);
        check("rst_sdata", 64'(i2s_sdata), 64'd0);
        check("rst_level", 64'(fifo_level), 64'd0);
        check("rst_ready", 64'(in_ready), 64'd1);
        check("rst_underflow", 64'(underflow_sticky), 64'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic push_sample(input logic [23:0] d);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_frames(input int target, input string name);
        bit done = 1'b0;
        for (int i = 0; i < 8 * FRAME_CYC && !done; i++) begin
            @(posedge clk);
            if (frames_done >= target) done = 1'b1;
        end
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: actual %0d frames required %0d", name, frames_done, target);
        end
    endtask

    initial begin
        vals = '{24'h123456, 24'hFEDCBA, 24'h000001, 24'h7FFFFF, 24'hBADBAD};

        // Basic frame, plus a sample pushed mid-frame into an empty buffer.
        do_reset();
        push_sample(24'hA5A5A5);
        exp_q.push_back(24'hA5A5A5);
        base = frames_done;
        @(negedge clk) enable = 1'b1;
        repeat (10) @(negedge clk);
        push_sample(24'h3C0F81);
        exp_q.push_back(24'h3C0F81);
        wait_frames(base + 2, "t1");
        @(negedge clk) enable = 1'b0;
        check("t1_underflow", 64'(underflow_sticky), 64'd0);
        check("t1_level", 64'(fifo_level), 64'd0);

        // Overfill while idle, then drain the four accepted samples.
        do_reset();
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = vals[i];
            check($sformatf("t2_ready_%0d", i), 64'(in_ready), (i < 4) ? 64'd1 : 64'd0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("t2_level_full", 64'(fifo_level), 64'd4);
        check("t2_ready_full", 64'(in_ready), 64'd0);
        for (int i = 0; i < 4; i++) exp_q.push_back(vals[i]);
        base = frames_done;
        @(negedge clk) enable = 1'b1;
        wait_frames(base + 4, "t2");
        @(negedge clk) enable = 1'b0;
        check("t2_level_end", 64'(fifo_level), 64'd0);
        check("t2_underflow", 64'(underflow_sticky), 64'd0);

        // Start with an empty buffer: zero frame and sticky underflow.
        do_reset();
        exp_q.push_back(24'h000000);
        base = frames_done;
        @(negedge clk) enable = 1'b1;
        check("t3_underflow_pre", 64'(underflow_sticky), 64'd0);
        @(negedge clk);
        check("t3_underflow_set", 64'(underflow_sticky), 64'd1);
        wait_frames(base + 1, "t3");
        @(negedge clk) enable = 1'b0;
        check("t3_underflow_held", 64'(underflow_sticky), 64'd1);
        @(negedge clk) clear_underflow = 1'b1;
        @(negedge clk) clear_underflow = 1'b0;
        check("t3_underflow_clr", 64'(underflow_sticky), 64'd0);

        // Mute at load pops the sample but transmits zeros for the whole frame.
        do_reset();
        push_sample(24'h800000);
        check("t4_level_pre", 64'(fifo_level), 64'd1);
        exp_q.push_back(24'h000000);
        base = frames_done;
        @(negedge clk);
        mute   = 1'b1;
        enable = 1'b1;
        @(negedge clk);
        check("t4_level_post", 64'(fifo_level), 64'd0);
        repeat (3) @(negedge clk);
        mute = 1'b0;
        wait_frames(base + 1, "t4");
        @(negedge clk) enable = 1'b0;
        check("t4_underflow", 64'(underflow_sticky), 64'd0);

        // Push coinciding with the frame-wrap pop keeps the level constant.
        do_reset();
        push_sample(24'h0F0F0F);
        push_sample(24'h55AA33);
        exp_q.push_back(24'h0F0F0F);
        exp_q.push_back(24'h55AA33);
        exp_q.push_back(24'hC3C3C3);
        base = frames_done;
        @(negedge clk) enable = 1'b1;
        @(negedge clk);
        check("t5_level_entry", 64'(fifo_level), 64'd1);
        wait_frames(base + 1, "t5a");
        @(negedge clk);
        check("t5_level_before", 64'(fifo_level), 64'd1);
        in_valid = 1'b1;
        in_data  = 24'hC3C3C3;
        @(negedge clk);
        in_valid = 1'b0;
        check("t5_level_wrap", 64'(fifo_level), 64'd1);
        @(negedge clk);
        check("t5_level_after", 64'(fifo_level), 64'd1);
        wait_frames(base + 3, "t5b");
        @(negedge clk) enable = 1'b0;
        check("t5_level_end", 64'(fifo_level), 64'd0);

        // Reset mid-frame at bit 40, then a fresh frame with clear held at entry.
        do_reset();
        @(negedge clk) enable = 1'b1;
        begin
            bit hit = 1'b0;
            for (int i = 0; i < 2 * FRAME_CYC && !hit; i++) begin
                @(posedge clk);
                if (bitpos == 41) hit = 1'b1;
            end
            if (!hit) begin
                n_tests++;
                n_fail++;
                $display("FAIL t6_bit40_timeout: actual bitpos %0d required 41", bitpos);
            end
        end
        @(negedge clk);
        check("t6_lrclk_pre", 64'(i2s_lrclk), 64'd1);
        check("t6_underflow_pre", 64'(underflow_sticky), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check("t6_rst_bclk", 64'(i2s_bclk), 64'd0);
        check("t6_rst_lrclk", 64'(i2s_lrclk), 64'd0);
        check("t6_rst_sdata", 64'(i2s_sdata), 64'd0);
        check("t6_rst_level", 64'(fifo_level), 64'd0);
        check("t6_rst_ready", 64'(in_ready), 64'd1);
        check("t6_rst_underflow", 64'(underflow_sticky), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        clear_underflow = 1'b1;
        exp_q.push_back(24'h000000);
        base = frames_done;
        @(negedge clk);
        clear_underflow = 1'b0;
        check("t6_set_priority", 64'(underflow_sticky), 64'd1);
        wait_frames(base + 1, "t6");
        @(negedge clk) enable = 1'b0;

        repeat (4) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "bench watchdog expired");
    end

endmodule
